// File: rtl/vc_link_if.sv
// Bundle between the VC buffers of one output port, the link stage and the
// scheduler that shares the link among the virtual channels.
interface vc_link_if #(
  parameter int NUM_VCS = 4,
  parameter int CW      = 5,
  parameter int VCW     = 2
);
  logic                   link_ready;
  logic [NUM_VCS-1:0]     vc_empty;
  logic [NUM_VCS-1:0]     vc_tail;
  logic [NUM_VCS-1:0]     vc_rd_en;
  logic                   out_valid;
  logic [VCW-1:0]         out_vc;
  logic                   out_tail;
  logic [NUM_VCS-1:0]     credit_ret;
  logic [NUM_VCS*CW-1:0]  credit_cnt;
  logic                   locked;
  logic [VCW-1:0]         lock_vc;
  logic                   credit_err;

  modport slave (
    input  link_ready, vc_empty, vc_tail, credit_ret,
    output vc_rd_en, out_valid, out_vc, out_tail, credit_cnt, locked, lock_vc, credit_err
  );

  modport master (
    output link_ready, vc_empty, vc_tail, credit_ret,
    input  vc_rd_en, out_valid, out_vc, out_tail, credit_cnt, locked, lock_vc, credit_err
  );
endinterface

// File: rtl/vc_link_scheduler.sv
// Round-robin, credit-aware link scheduler: pops one VC buffer per cycle and
// holds the grant on a VC from head flit to tail flit.
module vc_link_scheduler #(
  parameter int NUM_VCS      = 4,
  parameter int CREDIT_DEPTH = 16,
  parameter int CW           = 5,
  parameter int VCW          = 2
) (
  input logic     clk,
  input logic     rst,
  vc_link_if.slave lnk
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDIT_DEPTH);
  localparam logic [VCW-1:0] LAST_VC  = VCW'(NUM_VCS - 1);

  function automatic logic [VCW-1:0] rr_idx(input logic [VCW-1:0] base, input int k);
    return VCW'((int'(base) + k) % NUM_VCS);
  endfunction

  // Saturating credit update; a simultaneous issue and return cancel out.
  function automatic logic [CW-1:0] credit_upd(input logic [CW-1:0] cur,
                                               input logic inc, input logic dec);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != CRED_MAX)) nxt = cur + CW'(1);
    else if (dec && !inc)                 nxt = cur - CW'(1);
    return nxt;
  endfunction

  state_e             state_q, state_d;
  logic [VCW-1:0]     last_grant_q, last_grant_d;
  logic [CW-1:0]      credit_q [NUM_VCS];
  logic [CW-1:0]      credit_d [NUM_VCS];
  logic               credit_err_q, credit_err_d;
  logic               out_valid_q;
  logic [VCW-1:0]     out_vc_q;
  logic               out_tail_q;

  logic [NUM_VCS-1:0] eligible;
  logic [NUM_VCS-1:0] rd_en;
  logic               grant_vld;
  logic [VCW-1:0]     grant_idx;
  logic               issue;
  logic [VCW-1:0]     issue_vc;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      eligible[i] = !lnk.vc_empty[i] && (credit_q[i] != '0);
    end
  end

  // Scan farthest-first so the nearest eligible VC after last_grant wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant_q;
    for (int k = NUM_VCS; k >= 1; k--) begin
      if (eligible[rr_idx(last_grant_q, k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx(last_grant_q, k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    issue_vc     = last_grant_q;
    rd_en        = '0;
    if (!rst && lnk.link_ready) begin
      unique case (state_q)
        IDLE: begin
          if (grant_vld) begin
            issue    = 1'b1;
            issue_vc = grant_idx;
            if (!lnk.vc_tail[grant_idx]) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (eligible[last_grant_q]) begin
            issue = 1'b1;
            if (lnk.vc_tail[last_grant_q]) state_d = IDLE;
          end
        end
      endcase
    end
    last_grant_d = issue_vc;
    if (issue) rd_en = NUM_VCS'(1) << issue_vc;
  end

  always_comb begin
    credit_err_d = credit_err_q;
    for (int i = 0; i < NUM_VCS; i++) begin
      credit_d[i] = credit_upd(credit_q[i], lnk.credit_ret[i], rd_en[i]);
      if (lnk.credit_ret[i] && !rd_en[i] && (credit_q[i] == CRED_MAX)) credit_err_d = 1'b1;
    end
  end

  // Registered stage: state, credits and the flit tag aligned with rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_VC;
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_vc_q     <= '0;
      out_tail_q   <= 1'b0;
      for (int i = 0; i < NUM_VCS; i++) credit_q[i] <= CRED_MAX;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= issue;
      if (issue) begin
        out_vc_q   <= issue_vc;
        out_tail_q <= lnk.vc_tail[issue_vc];
      end
      for (int i = 0; i < NUM_VCS; i++) credit_q[i] <= credit_d[i];
    end
  end

  for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_cnt
    assign lnk.credit_cnt[gi*CW +: CW] = credit_q[gi];
  end

  assign lnk.vc_rd_en   = rd_en;
  assign lnk.out_valid  = out_valid_q;
  assign lnk.out_vc     = out_vc_q;
  assign lnk.out_tail   = out_tail_q;
  assign lnk.locked     = (state_q == LOCKED);
  assign lnk.lock_vc    = last_grant_q;
  assign lnk.credit_err = credit_err_q;

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Directed bench for vc_link_scheduler: vector table for arbitration and
// locking, plus hand sequences for credits, credit errors and mid-packet reset.
module tb_vc_link_scheduler;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  vc_link_if #(.NUM_VCS(4), .CW(5), .VCW(2)) lnk ();

  vc_link_scheduler #(.NUM_VCS(4), .CREDIT_DEPTH(16), .CW(5), .VCW(2)) dut (
    .clk (clk),
    .rst (rst),
    .lnk (lnk.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lr;
    logic [3:0] emp;
    logic [3:0] tail;
    logic [3:0] cret;
    logic [3:0] exp_rd;
    logic       exp_ov;
    logic [1:0] exp_ovc;
    logic       exp_ot;
    logic       exp_lk;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic r, input logic lr, input logic [3:0] e,
                            input logic [3:0] t, input logic [3:0] c, input logic [3:0] rd,
                            input logic ov, input logic [1:0] ovc, input logic ot,
                            input logic lk);
    vec_t x;
    x.rst = r; x.lr = lr; x.emp = e; x.tail = t; x.cret = c;
    x.exp_rd = rd; x.exp_ov = ov; x.exp_ovc = ovc; x.exp_ot = ot; x.exp_lk = lk;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step(input logic r, input logic lr, input logic [3:0] e,
                      input logic [3:0] t, input logic [3:0] c);
    @(negedge clk);
    rst            = r;
    lnk.link_ready = lr;
    lnk.vc_empty   = e;
    lnk.vc_tail    = t;
    lnk.credit_ret = c;
    #1;
  endtask

  function automatic logic [4:0] cred(input int i);
    return lnk.credit_cnt[i*5 +: 5];
  endfunction

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    lnk.link_ready = 1'b0;
    lnk.vc_empty   = 4'hF;
    lnk.vc_tail    = 4'h0;
    lnk.credit_ret = 4'h0;

    // rst, lr, emp, tail, cret | rd_en, out_valid, out_vc, out_tail, locked
    v(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    // round robin over single-flit packets
    v(0, 1, 4'h0, 4'hF, 4'h0, 4'h1, 0, 0, 0, 0);
    v(0, 1, 4'h0, 4'hF, 4'h0, 4'h2, 1, 0, 1, 0);
    v(0, 1, 4'h0, 4'hF, 4'h0, 4'h4, 1, 1, 1, 0);
    v(0, 1, 4'h0, 4'hF, 4'h0, 4'h8, 1, 2, 1, 0);
    v(0, 1, 4'h0, 4'hF, 4'h0, 4'h1, 1, 3, 1, 0);
    v(0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 1, 0, 1, 0);
    v(0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0);
    // 3-flit packet on VC1 with VC2 waiting
    v(0, 1, 4'h9, 4'h4, 4'h0, 4'h2, 0, 0, 0, 0);
    v(0, 1, 4'h9, 4'h4, 4'h0, 4'h2, 1, 1, 0, 1);
    v(0, 1, 4'h9, 4'h6, 4'h0, 4'h2, 1, 1, 0, 1);
    v(0, 1, 4'h9, 4'h6, 4'h0, 4'h4, 1, 1, 1, 0);
    v(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 2, 1, 0);
    // lock on VC0, VC0 runs dry while VC3 is eligible
    v(0, 1, 4'hE, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0);
    v(0, 1, 4'h7, 4'h8, 4'h0, 4'h0, 1, 0, 0, 1);
    v(0, 1, 4'h7, 4'h8, 4'h0, 4'h0, 0, 0, 0, 1);
    v(0, 1, 4'h6, 4'h9, 4'h0, 4'h1, 0, 0, 0, 1);
    v(0, 1, 4'h7, 4'h8, 4'h0, 4'h8, 1, 0, 1, 0);
    v(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 3, 1, 0);
    // link back-pressure
    v(0, 0, 4'hE, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0);
    v(0, 1, 4'hE, 4'hF, 4'h0, 4'h1, 0, 0, 0, 0);
    v(0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 1, 0, 1, 0);

    step(1, 0, 4'hF, 4'h0, 4'h0);
    step(1, 0, 4'hF, 4'h0, 4'h0);
    chk("reset_lock_vc", 32'(lnk.lock_vc), 32'd3);
    chk("reset_credit_err", 32'(lnk.credit_err), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].lr, tbl[i].emp, tbl[i].tail, tbl[i].cret);
      chk($sformatf("vec%0d_rd_en", i), 32'(lnk.vc_rd_en), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_out_valid", i), 32'(lnk.out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("vec%0d_locked", i), 32'(lnk.locked), 32'(tbl[i].exp_lk));
      if (tbl[i].exp_ov) begin
        chk($sformatf("vec%0d_out_vc", i), 32'(lnk.out_vc), 32'(tbl[i].exp_ovc));
        chk($sformatf("vec%0d_out_tail", i), 32'(lnk.out_tail), 32'(tbl[i].exp_ot));
      end
    end
    chk("tbl_credit0", 32'(cred(0)), 32'd11);
    chk("tbl_credit1", 32'(cred(1)), 32'd12);
    chk("tbl_credit2", 32'(cred(2)), 32'd14);
    chk("tbl_credit3", 32'(cred(3)), 32'd14);

    // credit exhaustion on VC2
    step(1, 0, 4'hF, 4'h0, 4'h0);
    step(1, 0, 4'hF, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 4'hB, 4'hF, 4'h0);
      chk($sformatf("exh_issue%0d", i), 32'(lnk.vc_rd_en), 32'h4);
    end
    step(0, 1, 4'hB, 4'hF, 4'h0);
    chk("exh_starved_rd", 32'(lnk.vc_rd_en), 32'h0);
    chk("exh_credit_zero", 32'(cred(2)), 32'd0);
    step(0, 1, 4'hB, 4'hF, 4'h4);
    chk("exh_ret_cycle_rd", 32'(lnk.vc_rd_en), 32'h0);
    step(0, 1, 4'hB, 4'hF, 4'h0);
    chk("exh_one_more_rd", 32'(lnk.vc_rd_en), 32'h4);
    chk("exh_credit_one", 32'(cred(2)), 32'd1);
    step(0, 1, 4'hB, 4'hF, 4'h0);
    chk("exh_starved_again", 32'(lnk.vc_rd_en), 32'h0);
    chk("exh_credit_zero2", 32'(cred(2)), 32'd0);

    // same-cycle issue and return, then an overflowing return
    step(1, 0, 4'hF, 4'h0, 4'h0);
    step(1, 0, 4'hF, 4'h0, 4'h0);
    for (int i = 0; i < 9; i++) step(0, 1, 4'hE, 4'hF, 4'h0);
    step(0, 1, 4'hF, 4'hF, 4'h0);
    chk("same_credit_before", 32'(cred(0)), 32'd7);
    chk("same_err_before", 32'(lnk.credit_err), 32'd0);
    step(0, 1, 4'hE, 4'hF, 4'h1);
    chk("same_issue_rd", 32'(lnk.vc_rd_en), 32'h1);
    step(0, 1, 4'hF, 4'hF, 4'h0);
    chk("same_credit_after", 32'(cred(0)), 32'd7);
    step(0, 1, 4'hF, 4'hF, 4'h2);
    step(0, 1, 4'hF, 4'hF, 4'h0);
    chk("ovf_credit_sat", 32'(cred(1)), 32'd16);
    chk("ovf_err_set", 32'(lnk.credit_err), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 4'hF, 4'hF, 4'h0);
    chk("ovf_err_sticky", 32'(lnk.credit_err), 32'd1);
    step(1, 0, 4'hF, 4'h0, 4'h0);
    step(0, 0, 4'hF, 4'h0, 4'h0);
    chk("ovf_err_cleared", 32'(lnk.credit_err), 32'd0);

    // reset mid-packet while locked on VC3
    step(1, 0, 4'hF, 4'h0, 4'h0);
    step(0, 1, 4'h7, 4'h0, 4'h0);
    chk("mid_first_rd", 32'(lnk.vc_rd_en), 32'h8);
    step(0, 1, 4'h7, 4'h0, 4'h0);
    chk("mid_locked", 32'(lnk.locked), 32'd1);
    chk("mid_lock_vc", 32'(lnk.lock_vc), 32'd3);
    step(1, 1, 4'h7, 4'h0, 4'h0);
    chk("mid_rst_rd", 32'(lnk.vc_rd_en), 32'h0);
    step(0, 1, 4'h0, 4'hF, 4'h0);
    chk("mid_after_locked", 32'(lnk.locked), 32'd0);
    chk("mid_after_valid", 32'(lnk.out_valid), 32'd0);
    chk("mid_after_credits", 32'(lnk.credit_cnt), 32'(20'h84210));
    chk("mid_after_grant", 32'(lnk.vc_rd_en), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vc_link_scheduler.md
Name: vc_link_scheduler

Overview:
- Shares one physical output link between NUM_VCS virtual-channel FIFO buffers, one per VC.
- Each cycle it selects at most one VC by round-robin, pops it via a read-enable pulse and tracks per-VC downstream credits.
- Holds the grant to one VC from head flit to tail flit, so packets are never interleaved on the link.
- Sits between the VC buffers of an output port and the link/crossbar stage of the router.

Parameters:
- NUM_VCS, 4, number of virtual channels; must be 2..8.
- CREDIT_DEPTH, 16, downstream buffer depth per VC; also the credit reset value and the credit maximum.
- CW, 5, credit counter width; must satisfy 2^CW > CREDIT_DEPTH.
- VCW, 2, VC index width, equal to clog2(NUM_VCS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- link_ready  in  1  link can accept a flit next cycle.
- vc_empty  in  NUM_VCS  per-VC buffer empty flag.
- vc_tail  in  NUM_VCS  head-of-queue flit of VC i is a tail (single-flit packets set it too).
- vc_rd_en  out  NUM_VCS  one-hot-or-zero pop strobe to the VC buffers; combinational.
- out_valid  out  1  registered; the buffer rd_data presented this cycle is a valid link flit.
- out_vc  out  VCW  registered VC index of the flit flagged by out_valid.
- out_tail  out  1  registered tail flag of that flit.
- credit_ret  in  NUM_VCS  per-VC credit return pulse from downstream; several may be set at once.
- credit_cnt  out  NUM_VCS*CW  packed current credits; VC i occupies bits [i*CW +: CW].
- locked  out  1  FSM is in LOCKED.
- lock_vc  out  VCW  VC owning the lock; last granted VC when idle.
- credit_err  out  1  sticky flag: a credit return arrived while that VC was already at CREDIT_DEPTH.

Behaviour:
- Eligibility: VC i is eligible when !vc_empty[i] && credit[i] != 0. An issue requires link_ready=1.
- FSM states: IDLE and LOCKED.
- IDLE:
  - If link_ready and any VC is eligible, grant the first eligible VC searching from (last_grant+1) mod NUM_VCS upward with wrap.
  - Pulse vc_rd_en[g] in that same cycle and set last_grant<=g.
  - If vc_tail[g]=1, stay in IDLE. Otherwise set lock_vc<=g and go to LOCKED.
- LOCKED:
  - Only lock_vc may issue. If it is not eligible, or link_ready=0, vc_rd_en stays 0 (bubble). Other VCs never issue, even if eligible.
  - On an issue with vc_tail[lock_vc]=1, go to IDLE. The next arbitration starts after lock_vc.
- Issue latency: the pop in cycle N produces out_valid=1, out_vc=g and out_tail=vc_tail[g] (as sampled in N) in cycle N+1, aligned with the buffer's registered rd_data. With no issue in cycle N, out_valid=0 in N+1.
- Credits:
  - An issue on VC i decrements credit[i]. credit_ret[i] increments credit[i].
  - Issue and return on the same VC in the same cycle leave the count unchanged.
  - A return while credit[i]==CREDIT_DEPTH (with no simultaneous issue) saturates at CREDIT_DEPTH and sets credit_err.
  - Credit never underflows, because eligibility requires credit != 0.
- Round-robin wrap: after VC NUM_VCS-1 is granted, VC 0 has highest priority.
- Throughput: one flit per cycle back-to-back is possible, from one VC or alternating VCs.
- Reset (any cycle, including mid-packet):
  - state=IDLE, vc_rd_en=0, out_valid=0, out_vc=0, out_tail=0.
  - credit[i]=CREDIT_DEPTH, last_grant=NUM_VCS-1 (so VC 0 wins first), lock_vc=NUM_VCS-1, locked=0, credit_err=0.
  - A partial packet is abandoned; flushing the buffers is the surrounding logic's job.
- vc_rd_en is driven only from registered state plus the current inputs; there are no paths from outputs back to inputs.

Test Plan:
- Reset then all VCs non-empty with vc_tail=1 and link_ready=1: grants 0,1,2,3,0 on consecutive cycles; out_valid=1 from cycle 2 onward; out_vc follows one cycle behind.
- VC1 sends a 3-flit packet (tail on the 3rd) while VC2 stays non-empty: vc_rd_en=0010 for 3 cycles, locked=1 for cycles 2–3, VC2 is granted on the 4th cycle.
- Lock on VC0, then vc_empty[0]=1 for 2 cycles while VC3 is eligible: two bubbles (vc_rd_en=0, out_valid=0 next cycle), VC3 is not granted; VC0 resumes when non-empty.
- VC2 alone issues 16 single flits with no returns: credit[2] reaches 0 and vc_rd_en[2] stays 0. One credit_ret[2] pulse lets exactly one more flit issue.
- Issue and credit_ret on VC0 in the same cycle at credit 7: credit stays 7. A credit_ret[1] at credit 16: credit stays 16 and credit_err=1 stays set until reset.
- Assert rst mid-packet while locked on VC3: the next cycle shows locked=0, out_valid=0 and all credits=16; the first grant after reset goes to VC 0.
